fxu_reservation_station: RTL and testbench
==========================================

FXU_RESERVATION_STATION -- requirements
Module: fxu_reservation_station

Interface
REQ-001 Parameter DEPTH, default 4: number of entries, 2..8.
REQ-002 Parameter DATA_W, default 16: operand and result width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_instr_valid  in  1  dispatch request from the instruction buffer.
REQ-006 in_rob_idx  in  4  destination ROB tag.
REQ-007 in_a_valid, in_b_valid  in  1 each  operand already holds its value.
REQ-008 in_a_value, in_b_value  in  DATA_W each  operand values, meaningful when valid.
REQ-009 in_a_owner, in_b_owner  in  4 each  producer ROB tag, meaningful when not valid.
REQ-010 in_opcode  in  4; in_i  in  8  opcode and immediate, stored unmodified.
REQ-011 full  out  1  no free entry; consumed by the dispatcher in the same cycle.
REQ-012 cdb_valid  in  1; cdb_rob_idx  in  4; cdb_value  in  DATA_W  result broadcast.
REQ-013 flush  in  1  discard all entries.
REQ-014 out_valid  out  1; out_ready  in  1  issue handshake to the FXU.
REQ-015 out_rob_idx 4, out_a 16, out_b 16, out_opcode 4, out_i 8  out  issued instruction fields.

Function
REQ-016 Entry fields: busy, rob_idx, a_rdy, a_val, a_tag, b_rdy, b_val, b_tag, opcode, imm.
REQ-017 full SHALL be 1 iff all DEPTH entries are busy, from registered state only; a same-cycle issue does not clear it.
REQ-018 in_instr_valid while full or flush SHALL be dropped with no state change.
REQ-019 An accepted dispatch SHALL write the lowest-indexed non-busy entry and set busy at the next edge.
REQ-020 Dispatch capture: an operand with valid=0 whose owner equals cdb_rob_idx while cdb_valid=1 in the same cycle SHALL be stored as ready with cdb_value.
REQ-021 Wakeup: each cycle, every busy entry with a_rdy=0 and a_tag==cdb_rob_idx under cdb_valid SHALL set a_rdy and load cdb_value; the same rule applies independently to b.
REQ-022 An entry is issuable when busy, a_rdy and b_rdy are all 1.
REQ-023 Select the lowest-indexed issuable entry; out_valid=1 iff one exists; outputs combinational from that entry.
REQ-024 On out_valid & out_ready the selected entry SHALL clear busy at the edge; in the same cycle that slot may not be reallocated.
REQ-025 out_valid high with out_ready low: selection and output fields SHALL stay stable unless a lower-indexed entry becomes issuable.
REQ-026 Latency: dispatch with both operands valid at edge t gives out_valid in cycle t+1.
REQ-027 The same tag on both operands SHALL wake both from one broadcast.
REQ-028 flush=1: all busy bits SHALL clear at the edge, and any handshake in that cycle is void.

Reset
REQ-029 rst_n=0 at an edge SHALL clear every busy, a_rdy and b_rdy; datapath fields are don't-care.
REQ-030 While and after reset, until the next dispatch: full=0, out_valid=0; out_* fields SHALL be driven 0.
REQ-031 Reset SHALL take priority over flush, dispatch and issue, including mid-operation.

Configuration
REQ-032 Macro RS_WAKEUP_BYPASS_EN: when defined, an entry missing only operands that match the current CDB broadcast SHALL be issuable in that cycle, with the value muxed from cdb_value.
REQ-033 Without RS_WAKEUP_BYPASS_EN, wakeup is registered and the entry becomes issuable one cycle after the broadcast.

Structure
REQ-034 Shared package ooo_pkg: ROB_IDX_W=4, DATA_W=16, OPCODE_W=4, IMM_W=8 and typedef rs_entry_t; the instruction buffer and ROB use the same constants.
REQ-035 One sub-module, rs_priority_pick: DEPTH-bit request vector in, one-hot grant and index out; used for both allocation and issue selection.

Verification
REQ-036 Dispatch rob 3, a=5, b=7, both valid, out_ready=1 -> out_valid in the next cycle with rob 3, a 5, b 7; busy cleared after the handshake.
REQ-037 Dispatch rob 2 with a_owner 9 not valid; CDB tag 9 value 0x1234 two cycles later -> issue with out_a=0x1234; cycle is broadcast+1 without the macro, broadcast cycle with it.
REQ-038 Dispatch with b_owner 6 in the same cycle as CDB tag 6 value 0x00FF -> entry stored ready and issues with out_b=0x00FF.
REQ-039 Fill 4 entries with out_ready=0 -> full=1; a 5th dispatch is dropped; one handshake -> full=0 next cycle; a dispatch in the handshake cycle is dropped.
REQ-040 Entries 1 and 3 ready, out_ready=1 -> entry 1 issues first, entry 3 next cycle.
REQ-041 flush or rst_n=0 with 3 busy entries and a concurrent dispatch -> all empty next cycle, out_valid=0, full=0.

Source files
------------

// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg
// Widths shared by the out-of-order core: the instruction buffer, the ROB and
// the fixed-point reservation station all import these so that ROB tags and
// operand values line up on every interface.
//
// Contents:
//   ROB_IDX_W  - width of a reorder-buffer tag
//   DATA_W     - operand / result width
//   OPCODE_W   - FXU opcode width
//   IMM_W      - immediate width
//   rs_entry_t - one reservation-station slot
// ---------------------------------------------------------------------------
package ooo_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int DATA_W    = 16;
    localparam int OPCODE_W  = 4;
    localparam int IMM_W     = 8;

    // An operand is either ready (rdy=1, val holds the value) or waiting on
    // the ROB entry named by tag to broadcast its result on the CDB.
    typedef struct packed {
        logic                 busy;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 a_rdy;
        logic [DATA_W-1:0]    a_val;
        logic [ROB_IDX_W-1:0] a_tag;
        logic                 b_rdy;
        logic [DATA_W-1:0]    b_val;
        logic [ROB_IDX_W-1:0] b_tag;
        logic [OPCODE_W-1:0]  opcode;
        logic [IMM_W-1:0]     imm;
    } rs_entry_t;

endpackage

// File: rtl/rs_priority_pick.sv
// ---------------------------------------------------------------------------
// rs_priority_pick
// Fixed-priority arbiter: the lowest-indexed asserted request wins.
// Used by the reservation station both to find a free slot for dispatch and
// to choose which ready slot issues to the FXU.
//
// Ports:
//   req  in   N      request vector
//   gnt  out  N      one-hot grant, all zero when no request is set
//   idx  out  IDX_W  binary index of the granted request (0 when none)
// ---------------------------------------------------------------------------
module rs_priority_pick #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    // Walk from the top index down so the last hit, i.e. the lowest
    // asserted request, is the one left standing.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fxu_reservation_station.sv
// ---------------------------------------------------------------------------
// fxu_reservation_station
// Holds dispatched FXU instructions until both operands are available, snoops
// the common data bus for missing operands, and issues the lowest-indexed
// ready entry to the FXU through a valid/ready handshake.
//
// Optional feature: define RS_WAKEUP_BYPASS_EN to let an entry whose only
// missing operands are being broadcast this cycle issue immediately, with
// those operands taken straight from cdb_value. Without it, wakeup is
// registered and the entry issues the cycle after the broadcast.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_instr_valid                  dispatch request
//   in_rob_idx                      destination ROB tag
//   in_a_valid / in_b_valid         operand already holds its value
//   in_a_value / in_b_value         operand values (when valid)
//   in_a_owner / in_b_owner         producer ROB tag (when not valid)
//   in_opcode, in_i                 opcode and immediate, stored as-is
//   full                            every entry busy (registered state only)
//   cdb_valid, cdb_rob_idx,         result broadcast
//   cdb_value
//   flush                           discard all entries
//   out_valid, out_ready            issue handshake
//   out_rob_idx, out_a, out_b,      issued instruction fields, zero when
//   out_opcode, out_i               out_valid is low
//
// DATA_W is expected to match ooo_pkg::DATA_W, since slots are stored as
// ooo_pkg::rs_entry_t.
// ---------------------------------------------------------------------------
module fxu_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_instr_valid,
    input  logic [ooo_pkg::ROB_IDX_W-1:0] in_rob_idx,
    input  logic                          in_a_valid,
    input  logic                          in_b_valid,
    input  logic [DATA_W-1:0]             in_a_value,
    input  logic [DATA_W-1:0]             in_b_value,
    input  logic [ooo_pkg::ROB_IDX_W-1:0] in_a_owner,
    input  logic [ooo_pkg::ROB_IDX_W-1:0] in_b_owner,
    input  logic [ooo_pkg::OPCODE_W-1:0]  in_opcode,
    input  logic [ooo_pkg::IMM_W-1:0]     in_i,
    output logic                          full,
    input  logic                          cdb_valid,
    input  logic [ooo_pkg::ROB_IDX_W-1:0] cdb_rob_idx,
    input  logic [DATA_W-1:0]             cdb_value,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ooo_pkg::ROB_IDX_W-1:0] out_rob_idx,
    output logic [DATA_W-1:0]             out_a,
    output logic [DATA_W-1:0]             out_b,
    output logic [ooo_pkg::OPCODE_W-1:0]  out_opcode,
    output logic [ooo_pkg::IMM_W-1:0]     out_i
);

    import ooo_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        entries [DEPTH];
    rs_entry_t        dispatch_entry;

    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] a_hit;
    logic [DEPTH-1:0] b_hit;
    logic [DEPTH-1:0] issuable;
    logic [DEPTH-1:0] alloc_gnt;
    logic [DEPTH-1:0] issue_gnt;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] issue_idx;
    logic             accept;
    logic             fire;

    // Per-entry CDB snoop: a waiting operand whose producer tag is on the bus
    // this cycle. Both operands are matched independently, so one broadcast
    // wakes both when they share a producer.
    always_comb begin
        busy_vec = '0;
        a_hit    = '0;
        b_hit    = '0;
        issuable = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i] = entries[i].busy;
            a_hit[i]    = entries[i].busy && !entries[i].a_rdy && cdb_valid &&
                          (entries[i].a_tag == cdb_rob_idx);
            b_hit[i]    = entries[i].busy && !entries[i].b_rdy && cdb_valid &&
                          (entries[i].b_tag == cdb_rob_idx);
`ifdef RS_WAKEUP_BYPASS_EN
            issuable[i] = entries[i].busy &&
                          (entries[i].a_rdy || a_hit[i]) &&
                          (entries[i].b_rdy || b_hit[i]);
`else
            issuable[i] = entries[i].busy && entries[i].a_rdy && entries[i].b_rdy;
`endif
        end
    end

    // One arbiter finds the lowest free slot for dispatch, the other the
    // lowest ready slot for issue.
    rs_priority_pick #(.N(DEPTH)) u_alloc_pick (
        .req (~busy_vec),
        .gnt (alloc_gnt),
        .idx (alloc_idx)
    );

    rs_priority_pick #(.N(DEPTH)) u_issue_pick (
        .req (issuable),
        .gnt (issue_gnt),
        .idx (issue_idx)
    );

    // full looks only at registered busy bits, so an issue in the same cycle
    // never frees a slot for a same-cycle dispatch. A dispatch is taken only
    // when a free slot exists and no flush is in progress.
    always_comb begin
        full   = &busy_vec;
        accept = in_instr_valid && !flush && (|alloc_gnt);
        fire   = out_valid && out_ready;
    end

    // Build the slot image for a new dispatch. An operand not yet valid whose
    // producer is broadcasting right now is captured as ready, otherwise the
    // broadcast would be missed and the entry would wait forever.
    always_comb begin
        dispatch_entry         = '0;
        dispatch_entry.busy    = 1'b1;
        dispatch_entry.rob_idx = in_rob_idx;
        dispatch_entry.a_tag   = in_a_owner;
        dispatch_entry.b_tag   = in_b_owner;
        dispatch_entry.opcode  = in_opcode;
        dispatch_entry.imm     = in_i;
        if (in_a_valid) begin
            dispatch_entry.a_rdy = 1'b1;
            dispatch_entry.a_val = in_a_value;
        end else if (cdb_valid && (in_a_owner == cdb_rob_idx)) begin
            dispatch_entry.a_rdy = 1'b1;
            dispatch_entry.a_val = cdb_value;
        end
        if (in_b_valid) begin
            dispatch_entry.b_rdy = 1'b1;
            dispatch_entry.b_val = in_b_value;
        end else if (cdb_valid && (in_b_owner == cdb_rob_idx)) begin
            dispatch_entry.b_rdy = 1'b1;
            dispatch_entry.b_val = cdb_value;
        end
    end

    // Slot state. Reset beats flush beats normal operation; flush also voids
    // any issue handshake in the same cycle. The dispatch target is never
    // busy, so it cannot collide with a wakeup or with the issuing slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].a_rdy <= 1'b0;
                entries[i].b_rdy <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_hit[i]) begin
                    entries[i].a_rdy <= 1'b1;
                    entries[i].a_val <= cdb_value;
                end
                if (b_hit[i]) begin
                    entries[i].b_rdy <= 1'b1;
                    entries[i].b_val <= cdb_value;
                end
            end
            if (fire) begin
                entries[issue_idx].busy <= 1'b0;
            end
            if (accept) begin
                entries[alloc_idx] <= dispatch_entry;
            end
        end
    end

    // Issue port, driven straight from the selected slot. Fields are forced
    // to zero when nothing is selected so the FXU never sees stale data.
    always_comb begin
        out_valid   = |issue_gnt;
        out_rob_idx = '0;
        out_a       = '0;
        out_b       = '0;
        out_opcode  = '0;
        out_i       = '0;
        if (out_valid) begin
            out_rob_idx = entries[issue_idx].rob_idx;
            out_a       = entries[issue_idx].a_val;
            out_b       = entries[issue_idx].b_val;
            out_opcode  = entries[issue_idx].opcode;
            out_i       = entries[issue_idx].imm;
`ifdef RS_WAKEUP_BYPASS_EN
            if (!entries[issue_idx].a_rdy) begin
                out_a = cdb_value;
            end
            if (!entries[issue_idx].b_rdy) begin
                out_b = cdb_value;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fxu_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_fxu_reservation_station
// Directed bench for fxu_reservation_station (DEPTH=4, DATA_W=16). Inputs are
// driven 1 time unit after each rising edge and outputs sampled 1 unit later.
// Expected values follow the RS_WAKEUP_BYPASS_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_fxu_reservation_station;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_instr_valid;
    logic [3:0]    in_rob_idx;
    logic          in_a_valid;
    logic          in_b_valid;
    logic [DW-1:0] in_a_value;
    logic [DW-1:0] in_b_value;
    logic [3:0]    in_a_owner;
    logic [3:0]    in_b_owner;
    logic [3:0]    in_opcode;
    logic [7:0]    in_i;
    logic          full;
    logic          cdb_valid;
    logic [3:0]    cdb_rob_idx;
    logic [DW-1:0] cdb_value;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_rob_idx;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [3:0]    out_opcode;
    logic [7:0]    out_i;

    int errors = 0;
    int checks = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    fxu_reservation_station #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_instr_valid (in_instr_valid),
        .in_rob_idx     (in_rob_idx),
        .in_a_valid     (in_a_valid),
        .in_b_valid     (in_b_valid),
        .in_a_value     (in_a_value),
        .in_b_value     (in_b_value),
        .in_a_owner     (in_a_owner),
        .in_b_owner     (in_b_owner),
        .in_opcode      (in_opcode),
        .in_i           (in_i),
        .full           (full),
        .cdb_valid      (cdb_valid),
        .cdb_rob_idx    (cdb_rob_idx),
        .cdb_value      (cdb_value),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rob_idx    (out_rob_idx),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_opcode     (out_opcode),
        .out_i          (out_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Opcode and immediate are derived from the ROB tag so each issued
    // instruction carries a distinct, predictable pattern.
    task automatic applyStimulus(input logic [3:0] rob,
                                 input logic av, input logic [DW-1:0] aval, input logic [3:0] aown,
                                 input logic bv, input logic [DW-1:0] bval, input logic [3:0] bown);
        in_instr_valid = 1'b1;
        in_rob_idx     = rob;
        in_a_valid     = av;
        in_a_value     = aval;
        in_a_owner     = aown;
        in_b_valid     = bv;
        in_b_value     = bval;
        in_b_owner     = bown;
        in_opcode      = rob ^ 4'h5;
        in_i           = {rob, ~rob};
    endtask

    task automatic idle();
        in_instr_valid = 1'b0;
        in_rob_idx     = '0;
        in_a_valid     = 1'b0;
        in_a_value     = '0;
        in_a_owner     = '0;
        in_b_valid     = 1'b0;
        in_b_value     = '0;
        in_b_owner     = '0;
        in_opcode      = '0;
        in_i           = '0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [DW-1:0] val);
        cdb_valid   = 1'b1;
        cdb_rob_idx = tag;
        cdb_value   = val;
    endtask

    task automatic quiet();
        cdb_valid   = 1'b0;
        cdb_rob_idx = '0;
        cdb_value   = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIssue(input string tag, input logic [3:0] rob,
                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [3:0] exp_op;
        logic [7:0] exp_imm;
        exp_op  = rob ^ 4'h5;
        exp_imm = {rob, ~rob};
        checkOutput({tag, ".valid"},  32'(out_valid),   32'd1);
        checkOutput({tag, ".rob"},    32'(out_rob_idx), 32'(rob));
        checkOutput({tag, ".a"},      32'(out_a),       32'(a));
        checkOutput({tag, ".b"},      32'(out_b),       32'(b));
        checkOutput({tag, ".opcode"}, 32'(out_opcode),  32'(exp_op));
        checkOutput({tag, ".imm"},    32'(out_i),       32'(exp_imm));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".full"},  32'(full),      32'd0);
    endtask

    task automatic checkZeroFields(input string tag);
        checkOutput({tag, ".rob"},    32'(out_rob_idx), 32'd0);
        checkOutput({tag, ".a"},      32'(out_a),       32'd0);
        checkOutput({tag, ".b"},      32'(out_b),       32'd0);
        checkOutput({tag, ".opcode"}, 32'(out_opcode),  32'd0);
        checkOutput({tag, ".imm"},    32'(out_i),       32'd0);
    endtask

    // Directed sequence: reset, single issue, CDB wakeup, dispatch capture,
    // full/backpressure, issue ordering, flush and mid-operation reset.
    initial begin
        idle();
        quiet();
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        $display("[TB] reset state");
        checkEmpty("rst");
        checkZeroFields("rst");
        rst_n = 1'b1;
        settle();
        checkEmpty("post_rst");

        // Both operands ready: visible the cycle after dispatch, gone after handshake.
        $display("[TB] single dispatch and issue");
        out_ready = 1'b1;
        applyStimulus(4'd3, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
        settle();
        checkOutput("t036.same_cycle", 32'(out_valid), 32'd0);
        tick();
        idle();
        settle();
        checkIssue("t036", 4'd3, 16'd5, 16'd7);
        tick();
        checkEmpty("t036.done");

        // Operand a waits on tag 9, broadcast two cycles after dispatch.
        $display("[TB] CDB wakeup");
        applyStimulus(4'd2, 1'b0, 16'd0, 4'd9, 1'b1, 16'h0022, 4'd0);
        tick();
        idle();
        settle();
        checkOutput("t037.wait", 32'(out_valid), 32'd0);
        tick();
        broadcast(4'd9, 16'h1234);
        settle();
`ifdef RS_WAKEUP_BYPASS_EN
        checkIssue("t037.bypass", 4'd2, 16'h1234, 16'h0022);
        tick();
        quiet();
        settle();
        checkEmpty("t037.done");
`else
        checkOutput("t037.bcast", 32'(out_valid), 32'd0);
        tick();
        quiet();
        settle();
        checkIssue("t037.woken", 4'd2, 16'h1234, 16'h0022);
        tick();
        checkEmpty("t037.done");
`endif

        // Operand b's producer broadcasts in the dispatch cycle itself.
        $display("[TB] dispatch capture");
        applyStimulus(4'd5, 1'b1, 16'h0011, 4'd0, 1'b0, 16'd0, 4'd6);
        broadcast(4'd6, 16'h00FF);
        settle();
        checkOutput("t038.same_cycle", 32'(out_valid), 32'd0);
        tick();
        idle();
        quiet();
        settle();
        checkIssue("t038", 4'd5, 16'h0011, 16'h00FF);
        tick();
        checkEmpty("t038.done");

        // Fill all four slots under backpressure, then probe full behaviour.
        $display("[TB] full and backpressure");
        out_ready = 1'b0;
        for (int r = 8; r <= 11; r++) begin
            applyStimulus(4'(r), 1'b1, 16'h0100 + 16'(r), 4'd0, 1'b1, 16'h0200 + 16'(r), 4'd0);
            settle();
            checkOutput($sformatf("t039.not_full_%0d", r), 32'(full), 32'd0);
            tick();
        end
        idle();
        settle();
        checkOutput("t039.full", 32'(full), 32'd1);
        checkIssue("t039.head", 4'd8, 16'h0108, 16'h0208);
        applyStimulus(4'd12, 1'b1, 16'h0C0C, 4'd0, 1'b1, 16'h0C0C, 4'd0);
        tick();
        idle();
        settle();
        checkOutput("t039.still_full", 32'(full), 32'd1);
        checkIssue("t039.stable", 4'd8, 16'h0108, 16'h0208);
        out_ready = 1'b1;
        applyStimulus(4'd13, 1'b1, 16'h0D0D, 4'd0, 1'b1, 16'h0D0D, 4'd0);
        settle();
        checkOutput("t039.full_during_issue", 32'(full), 32'd1);
        tick();
        idle();
        out_ready = 1'b0;
        settle();
        checkOutput("t039.freed", 32'(full), 32'd0);
        checkIssue("t039.next", 4'd9, 16'h0109, 16'h0209);
        out_ready = 1'b1;
        tick();
        checkIssue("t039.drain10", 4'd10, 16'h010A, 16'h020A);
        tick();
        checkIssue("t039.drain11", 4'd11, 16'h010B, 16'h020B);
        tick();
        checkEmpty("t039.drained");

        // Slots 1 and 3 ready, 0 and 2 waiting: 1 issues before 3.
        $display("[TB] issue ordering");
        out_ready = 1'b0;
        applyStimulus(4'd1, 1'b0, 16'd0, 4'd14, 1'b1, 16'd0, 4'd0);
        tick();
        applyStimulus(4'd4, 1'b1, 16'h0044, 4'd0, 1'b1, 16'h0045, 4'd0);
        tick();
        applyStimulus(4'd6, 1'b0, 16'd0, 4'd15, 1'b1, 16'd0, 4'd0);
        tick();
        applyStimulus(4'd7, 1'b1, 16'h0077, 4'd0, 1'b1, 16'h0078, 4'd0);
        tick();
        idle();
        settle();
        checkOutput("t040.full", 32'(full), 32'd1);
        checkIssue("t040.first", 4'd4, 16'h0044, 16'h0045);
        out_ready = 1'b1;
        tick();
        checkIssue("t040.second", 4'd7, 16'h0077, 16'h0078);
        tick();
        checkEmpty("t040.waiting_only");

        // Flush with three busy slots and a concurrent ready dispatch.
        $display("[TB] flush");
        out_ready = 1'b0;
        applyStimulus(4'd0, 1'b0, 16'd0, 4'd13, 1'b1, 16'd0, 4'd0);
        tick();
        out_ready = 1'b1;
        flush     = 1'b1;
        applyStimulus(4'd3, 1'b1, 16'h0033, 4'd0, 1'b1, 16'h0034, 4'd0);
        tick();
        flush = 1'b0;
        idle();
        settle();
        checkEmpty("t041.flush");
        broadcast(4'd14, 16'hBEEF);
        settle();
        checkOutput("t041.no_wake_now", 32'(out_valid), 32'd0);
        tick();
        quiet();
        settle();
        checkEmpty("t041.no_wake_next");
        applyStimulus(4'd10, 1'b1, 16'h00AA, 4'd0, 1'b1, 16'h00AB, 4'd0);
        tick();
        idle();
        settle();
        checkIssue("t041.reuse", 4'd10, 16'h00AA, 16'h00AB);
        tick();
        checkEmpty("t041.reuse_done");

        // Reset mid-operation, together with flush, dispatch, issue and CDB.
        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(4'(r), 1'b0, 16'd0, 4'd13, 1'b1, 16'd0, 4'd0);
            tick();
        end
        idle();
        rst_n     = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(4'd3, 1'b1, 16'h0033, 4'd0, 1'b1, 16'h0034, 4'd0);
        broadcast(4'd13, 16'h5555);
        tick();
        idle();
        quiet();
        flush = 1'b0;
        settle();
        checkEmpty("t041.rst");
        checkZeroFields("t041.rst");
        rst_n = 1'b1;
        broadcast(4'd13, 16'h5555);
        settle();
        checkOutput("t041.rst_no_wake", 32'(out_valid), 32'd0);
        tick();
        quiet();
        settle();
        checkEmpty("t041.rst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
